alu_seq: RTL and testbench

Parametrised, registered ALU for the dcpu datapath. Extends the basic 4-op ALU with carry-in arithmetic, subtraction, shifts/rotates, compare, and a multi-cycle unsigned multiplier, plus a start/busy/done handshake so the control unit can stall on long operations. All results and flags are registered. Flags persist between operations so chained ADC/SBC/rotates work.

---
 rtl/alu_seq.sv | 211 +++++++++++++++++++++
 tb/tb_alu_seq.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// Registered ALU with carry-chained arithmetic, shifts/rotates, compare and an
// iterative shift-and-add multiplier behind a start/busy/done handshake.
module alu_seq #(
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_start,
    input  logic [3:0]       i_op,
    input  logic [WIDTH-1:0] i_alu_l,
    input  logic [WIDTH-1:0] i_alu_r,
    output logic [WIDTH-1:0] o_alu,
    output logic [WIDTH-1:0] o_alu_hi,
    output logic [3:0]       o_flags,
    output logic             o_busy,
    output logic             o_done
);

    localparam int CW = $clog2(WIDTH);

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_AND = 4'd1;
    localparam logic [3:0] OP_OR  = 4'd2;
    localparam logic [3:0] OP_XOR = 4'd3;
    localparam logic [3:0] OP_ADC = 4'd4;
    localparam logic [3:0] OP_SUB = 4'd5;
    localparam logic [3:0] OP_SBC = 4'd6;
    localparam logic [3:0] OP_SHL = 4'd7;
    localparam logic [3:0] OP_SHR = 4'd8;
    localparam logic [3:0] OP_ASR = 4'd9;
    localparam logic [3:0] OP_ROL = 4'd10;
    localparam logic [3:0] OP_ROR = 4'd11;
    localparam logic [3:0] OP_MUL = 4'd12;
    localparam logic [3:0] OP_CMP = 4'd13;

    typedef enum logic [0:0] {
        ST_IDLE,
        ST_MUL
    } state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [2*WIDTH-1:0] prod_q, prod_d;
    logic [WIDTH-1:0]   alu_q, alu_d;
    logic [WIDTH-1:0]   alu_hi_q, alu_hi_d;
    logic [3:0]         flags_q, flags_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic               cin;
    logic [WIDTH:0]     arith;
    logic [WIDTH-1:0]   res;
    logic               res_c;
    logic               res_v;
    logic               wr_alu;
    logic               wr_flags;
    logic [2*WIDTH-1:0] prod_sum;
    logic               mul_last;

    assign cin = flags_q[1];

    // Single-cycle datapath: result and C/V for the op currently presented.
    // Arithmetic runs at WIDTH+1 bits so bit WIDTH is carry (add) or borrow (sub).
    always_comb begin
        arith    = '0;
        res      = alu_q;
        res_c    = cin;
        res_v    = 1'b0;
        wr_alu   = 1'b1;
        wr_flags = 1'b1;
        case (i_op)
            OP_ADD, OP_ADC: begin
                arith = {1'b0, i_alu_l} + {1'b0, i_alu_r}
                      + {{WIDTH{1'b0}}, (i_op == OP_ADC) & cin};
                res   = arith[WIDTH-1:0];
                res_c = arith[WIDTH];
                res_v = (i_alu_l[WIDTH-1] == i_alu_r[WIDTH-1]) &&
                        (arith[WIDTH-1] != i_alu_l[WIDTH-1]);
            end
            OP_SUB, OP_SBC, OP_CMP: begin
                arith = {1'b0, i_alu_l} - {1'b0, i_alu_r}
                      - {{WIDTH{1'b0}}, (i_op == OP_SBC) & cin};
                res   = arith[WIDTH-1:0];
                res_c = arith[WIDTH];
                res_v = (i_alu_l[WIDTH-1] != i_alu_r[WIDTH-1]) &&
                        (arith[WIDTH-1] != i_alu_l[WIDTH-1]);
                wr_alu = (i_op != OP_CMP);
            end
            OP_AND: res = i_alu_l & i_alu_r;
            OP_OR:  res = i_alu_l | i_alu_r;
            OP_XOR: res = i_alu_l ^ i_alu_r;
            OP_SHL: begin
                res   = {i_alu_l[WIDTH-2:0], 1'b0};
                res_c = i_alu_l[WIDTH-1];
            end
            OP_SHR: begin
                res   = {1'b0, i_alu_l[WIDTH-1:1]};
                res_c = i_alu_l[0];
            end
            OP_ASR: begin
                res   = {i_alu_l[WIDTH-1], i_alu_l[WIDTH-1:1]};
                res_c = i_alu_l[0];
            end
            OP_ROL: begin
                res   = {i_alu_l[WIDTH-2:0], cin};
                res_c = i_alu_l[WIDTH-1];
            end
            OP_ROR: begin
                res   = {cin, i_alu_l[WIDTH-1:1]};
                res_c = i_alu_l[0];
            end
            default: begin
                wr_alu   = 1'b0;
                wr_flags = 1'b0;
            end
        endcase
    end

    // Multiplier step: the multiplicand walks left while the multiplier walks right,
    // so each cycle adds exactly one partial product.
    assign prod_sum = prod_q + (mplier_q[0] ? mcand_q : '0);
    assign mul_last = (cnt_q == CW'(WIDTH - 1));

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        prod_d   = prod_q;
        alu_d    = alu_q;
        alu_hi_d = alu_hi_q;
        flags_d  = flags_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    if (i_op == OP_MUL) begin
                        mcand_d  = {{WIDTH{1'b0}}, i_alu_l};
                        mplier_d = i_alu_r;
                        prod_d   = '0;
                        cnt_d    = '0;
                        busy_d   = 1'b1;
                        state_d  = ST_MUL;
                    end else begin
                        done_d = 1'b1;
                        if (wr_alu) begin
                            alu_d = res;
                        end
                        if (wr_flags) begin
                            flags_d = {res_v, res[WIDTH-1], res_c, (res == '0)};
                        end
                    end
                end
            end
            ST_MUL: begin
                prod_d   = prod_sum;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 1'b1;
                if (mul_last) begin
                    alu_d    = prod_sum[WIDTH-1:0];
                    alu_hi_d = prod_sum[2*WIDTH-1:WIDTH];
                    flags_d  = {1'b0, prod_sum[2*WIDTH-1],
                                (prod_sum[2*WIDTH-1:WIDTH] != '0), (prod_sum == '0)};
                    busy_d   = 1'b0;
                    done_d   = 1'b1;
                    cnt_d    = '0;
                    state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Reset wins over a simultaneous start and silently abandons any multiply in flight.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            prod_q   <= '0;
            alu_q    <= '0;
            alu_hi_q <= '0;
            flags_q  <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            prod_q   <= prod_d;
            alu_q    <= alu_d;
            alu_hi_q <= alu_hi_d;
            flags_q  <= flags_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign o_alu    = alu_q;
    assign o_alu_hi = alu_hi_q;
    assign o_flags  = flags_q;
    assign o_busy   = busy_q;
    assign o_done   = done_q;

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: table of chained 8-bit ops through a done-driven scoreboard,
// plus directed multiply, reset-abort and 16-bit sequences.
module tb_alu_seq;

    localparam logic [3:0] ADD = 4'd0,  AND = 4'd1,  OR  = 4'd2,  XOR = 4'd3;
    localparam logic [3:0] ADC = 4'd4,  SUB = 4'd5,  SBC = 4'd6,  SHL = 4'd7;
    localparam logic [3:0] SHR = 4'd8,  ASR = 4'd9,  ROL = 4'd10, ROR = 4'd11;
    localparam logic [3:0] MUL = 4'd12, CMP = 4'd13, NOP = 4'd14;

    logic        clk = 1'b0;
    logic        rst;
    logic        start8, start16;
    logic [3:0]  op8, op16;
    logic [7:0]  l8, r8, alu8, hi8;
    logic [15:0] l16, r16, alu16, hi16;
    logic [3:0]  flags8, flags16;
    logic        busy8, done8, busy16, done16;

    int passCount  = 0;
    int totalCount = 0;

    typedef struct {
        logic [7:0] alu;
        logic [7:0] hi;
        logic [3:0] flags;
    } sb_t;

    typedef struct {
        logic [3:0] op;
        logic [7:0] l;
        logic [7:0] r;
        logic [7:0] expAlu;
        logic [3:0] expFlags;
    } vec_t;

    sb_t  sbQueue[$];
    vec_t vecs[21];

    always #5 clk = ~clk;

    alu_seq #(.WIDTH(8)) dut8 (
        .i_clk(clk), .i_reset(rst), .i_start(start8), .i_op(op8),
        .i_alu_l(l8), .i_alu_r(r8), .o_alu(alu8), .o_alu_hi(hi8),
        .o_flags(flags8), .o_busy(busy8), .o_done(done8)
    );

    alu_seq #(.WIDTH(16)) dut16 (
        .i_clk(clk), .i_reset(rst), .i_start(start16), .i_op(op16),
        .i_alu_l(l16), .i_alu_r(r16), .o_alu(alu16), .o_alu_hi(hi16),
        .o_flags(flags16), .o_busy(busy16), .o_done(done16)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        totalCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Drive one request for a single posedge; queue its expected completion if asked.
    task automatic applyStimulus(input logic [3:0] op, input logic [7:0] l, input logic [7:0] r,
                                 input sb_t e, input bit push);
        @(negedge clk);
        start8 = 1'b1;
        op8    = op;
        l8     = l;
        r8     = r;
        if (push) begin
            sbQueue.push_back(e);
        end
        @(posedge clk);
        #1 start8 = 1'b0;
    endtask

    // Every completion pulse retires the oldest expected result.
    always @(negedge clk) begin
        if (done8 === 1'b1) begin
            checkOutput("sb_pending", 32'(sbQueue.size() > 0), 32'd1);
            if (sbQueue.size() > 0) begin
                sb_t e;
                e = sbQueue.pop_front();
                checkOutput("sb_alu", 32'(alu8), 32'(e.alu));
                checkOutput("sb_hi", 32'(hi8), 32'(e.hi));
                checkOutput("sb_flags", 32'(flags8), 32'(e.flags));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        sb_t e;
        int  busyCnt;

        rst = 1'b1; start8 = 1'b0; start16 = 1'b0;
        op8 = '0; l8 = '0; r8 = '0; op16 = '0; l16 = '0; r16 = '0;

        // Flags chain from one vector to the next, so table order matters.
        vecs[0]  = '{ADD, 8'hFF, 8'h01, 8'h00, 4'b0011};
        vecs[1]  = '{ADC, 8'h00, 8'h00, 8'h01, 4'b0000};
        vecs[2]  = '{SUB, 8'h80, 8'h01, 8'h7F, 4'b1000};
        vecs[3]  = '{SUB, 8'h00, 8'h01, 8'hFF, 4'b0110};
        vecs[4]  = '{CMP, 8'h10, 8'h10, 8'hFF, 4'b0001};
        vecs[5]  = '{SHL, 8'h80, 8'h00, 8'h00, 4'b0011};
        vecs[6]  = '{ROR, 8'h02, 8'h00, 8'h81, 4'b0100};
        vecs[7]  = '{ASR, 8'h80, 8'h00, 8'hC0, 4'b0100};
        vecs[8]  = '{SHL, 8'h81, 8'h00, 8'h02, 4'b0010};
        vecs[9]  = '{AND, 8'hF0, 8'h3C, 8'h30, 4'b0010};
        vecs[10] = '{OR,  8'h00, 8'h00, 8'h00, 4'b0011};
        vecs[11] = '{XOR, 8'hAA, 8'h55, 8'hFF, 4'b0110};
        vecs[12] = '{ROL, 8'h40, 8'h00, 8'h81, 4'b0100};
        vecs[13] = '{SHR, 8'h01, 8'h00, 8'h00, 4'b0011};
        vecs[14] = '{SBC, 8'h05, 8'h02, 8'h02, 4'b0000};
        vecs[15] = '{NOP, 8'h12, 8'h34, 8'h02, 4'b0000};
        vecs[16] = '{ADD, 8'h7F, 8'h01, 8'h80, 4'b1100};
        vecs[17] = '{SBC, 8'h00, 8'h00, 8'h00, 4'b0001};
        vecs[18] = '{ADC, 8'hFF, 8'hFF, 8'hFE, 4'b0110};
        vecs[19] = '{ROR, 8'h01, 8'h00, 8'h80, 4'b0110};
        vecs[20] = '{SBC, 8'h80, 8'h00, 8'h7F, 4'b1000};

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checkOutput("reset_alu", 32'(alu8), 32'h0);
        checkOutput("reset_hi", 32'(hi8), 32'h0);
        checkOutput("reset_flags", 32'(flags8), 32'h0);
        checkOutput("reset_busy", 32'(busy8), 32'h0);
        checkOutput("reset_done", 32'(done8), 32'h0);
        checkOutput("reset16_alu", 32'(alu16), 32'h0);

        // Back-to-back table, one accept per cycle.
        foreach (vecs[i]) begin
            e = '{vecs[i].expAlu, 8'h00, vecs[i].expFlags};
            applyStimulus(vecs[i].op, vecs[i].l, vecs[i].r, e, 1'b1);
        end
        @(negedge clk);
        checkOutput("b2b_done_last", 32'(done8), 32'd1);
        @(negedge clk);
        checkOutput("done_one_wide", 32'(done8), 32'd0);

        // MUL 0xFF x 0xFF with an ADD request fired while busy.
        e = '{8'h01, 8'hFE, 4'b0110};
        applyStimulus(MUL, 8'hFF, 8'hFF, e, 1'b1);
        busyCnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            start8 = 1'b0;
            if (busy8 !== 1'b1) break;
            busyCnt++;
            if (busyCnt == 2) begin
                checkOutput("mul_hold_alu", 32'(alu8), 32'h7F);
                checkOutput("mul_hold_flags", 32'(flags8), 32'b1000);
            end
            if (busyCnt == 3) begin
                start8 = 1'b1; op8 = ADD; l8 = 8'h01; r8 = 8'h01;
            end
        end
        checkOutput("mul8_busy_cycles", 32'(busyCnt), 32'd8);
        checkOutput("mul8_done_at_k8", 32'(done8), 32'd1);
        @(negedge clk);
        checkOutput("mul8_done_one_wide", 32'(done8), 32'd0);

        // Non-MUL op must leave the high half alone.
        e = '{8'h02, 8'hFE, 4'b0000};
        applyStimulus(ADD, 8'h01, 8'h01, e, 1'b1);

        // Abort a MUL with reset four cycles in; nothing may complete.
        e = '{8'h00, 8'h00, 4'b0000};
        applyStimulus(MUL, 8'h0F, 8'h0F, e, 1'b0);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checkOutput("abort_alu", 32'(alu8), 32'h0);
        checkOutput("abort_hi", 32'(hi8), 32'h0);
        checkOutput("abort_flags", 32'(flags8), 32'h0);
        checkOutput("abort_busy", 32'(busy8), 32'h0);
        checkOutput("abort_done", 32'(done8), 32'h0);
        repeat (10) @(negedge clk);

        e = '{8'h07, 8'h00, 4'b0000};
        applyStimulus(ADD, 8'h03, 8'h04, e, 1'b1);
        @(negedge clk);
        checkOutput("post_reset_add_latency", 32'(done8), 32'd1);
        checkOutput("post_reset_add_alu", 32'(alu8), 32'h07);

        // Reset and start on the same edge: reset wins.
        @(negedge clk);
        rst = 1'b1; start8 = 1'b1; op8 = ADD; l8 = 8'h05; r8 = 8'h05;
        @(posedge clk);
        #1 rst = 1'b0; start8 = 1'b0;
        @(negedge clk);
        checkOutput("rst_start_done", 32'(done8), 32'd0);
        checkOutput("rst_start_alu", 32'(alu8), 32'h0);

        // 16-bit instance: MUL timing and signed overflow.
        @(negedge clk);
        start16 = 1'b1; op16 = MUL; l16 = 16'h1234; r16 = 16'h0010;
        @(posedge clk);
        #1 start16 = 1'b0; l16 = 16'hFFFF; r16 = 16'hFFFF;
        busyCnt = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (busy16 !== 1'b1) break;
            busyCnt++;
        end
        checkOutput("mul16_busy_cycles", 32'(busyCnt), 32'd16);
        checkOutput("mul16_done", 32'(done16), 32'd1);
        checkOutput("mul16_lo", 32'(alu16), 32'h2340);
        checkOutput("mul16_hi", 32'(hi16), 32'h0001);
        checkOutput("mul16_flags", 32'(flags16), 32'b0010);

        @(negedge clk);
        start16 = 1'b1; op16 = ADD; l16 = 16'h7FFF; r16 = 16'h0001;
        @(posedge clk);
        #1 start16 = 1'b0;
        @(negedge clk);
        checkOutput("add16_done", 32'(done16), 32'd1);
        checkOutput("add16_alu", 32'(alu16), 32'h8000);
        checkOutput("add16_flags", 32'(flags16), 32'b1100);
        checkOutput("add16_hi_kept", 32'(hi16), 32'h0001);

        repeat (3) @(negedge clk);
        checkOutput("sb_drain", 32'(sbQueue.size()), 32'd0);

        $display("%0d/%0d checks passed", passCount, totalCount);
        $finish;
    end

endmodule
